ascon_perm_core: RTL and testbench
==================================

// Module: ascon_perm_core
// PURPOSE
//  Iterative Ascon permutation engine: the consumer of the round index. Accepts a 320-bit
//  state over valid/ready, applies p12 or p6 (one round per cycle), returns result over valid/ready.
//  Sits between the mode controller (init/absorb/finalize sequencing) and the state register file.
// PARAMETERS
//  STATE_W   320  permutation state width (5 x 64-bit words; fixed by Ascon)
//  ROUND_W   4    round index width; indices 0..11
// PORTS
//  clk_i        in   1    single clock, all logic rising-edge
//  rst_i        in   1    synchronous, active-high reset
//  in_valid_i   in   1    input state valid
//  in_ready_o   out  1    core idle, can accept
//  p12_i        in   1    1: p12 (rounds 0..11), 0: p6 (rounds 6..11); sampled on accept
//  state_i      in   320  x0=[319:256] .. x4=[63:0]
//  out_valid_o  out  1    result valid
//  out_ready_i  in   1    downstream accepts result
//  state_o      out  320  permuted state, same packing; stable while out_valid_o=1
//  busy_o       out  1    1 in RUN or DONE
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): FSM=IDLE, round=0, state reg=0; in_ready_o=1, out_valid_o=0,
//    busy_o=0, state_o=0. Reset mid-RUN/DONE aborts; no result emitted.
//  - FSM IDLE -> RUN on in_valid_i&in_ready_o (edge e0): load state_i, round = p12_i ? 0 : 6.
//  - RUN: each edge apply one round with index r, r<=r+1; round applied at r=11 -> DONE.
//  - DONE: out_valid_o=1; on out_ready_i -> IDLE (in_ready_o=1 next cycle; no same-cycle
//    accept while DONE). in_ready_o = (FSM==IDLE) only.
//  - Latency: out_valid_o high after edge e0+12 (p12) / e0+6 (p6); back-to-back throughput
//    one permutation per 14 / 8 cycles with out_ready_i held 1.
//  - Round r: constant c_r = {(4'hF - r), r} XORed into x2[7:0] (r=0 -> 0xF0, r=6 -> 0x96,
//    r=11 -> 0x4B); then bitsliced S-box: x0^=x4; x4^=x3; x2^=x1; t_i=~x_i & x_(i+1 mod 5);
//    x_i^=t_(i+1 mod 5); x1^=x0; x0^=x4; x3^=x2; x2=~x2; then linear layer
//    x_i ^= ror(x_i,a_i) ^ ror(x_i,b_i), (a,b) = (19,28),(61,39),(1,6),(10,17),(7,41).
//  - All arithmetic 4-bit unsigned on round; round never exceeds 11 (no wrap).
//  - in_valid_i/state_i ignored outside IDLE; p12_i ignored outside accept cycle.
//  - out_ready_i with out_valid_o=0 has no effect.
// CONFIGURATION
//  ASCON_PERM_UNROLL2_EN defined: two cascaded rounds per RUN edge (r, r+1), r<=r+2;
//    latency e0+6 (p12) / e0+3 (p6); DONE when pair ending at r=11 applied.
//  Undefined: one round per edge as above. Results bit-identical in both builds.
// STRUCTURE
//  ascon_pkg: state_t (5 x logic[63:0]), pack/unpack functions, round_const(r) function,
//    rotation-amount constants, FSM enum {IDLE, RUN, DONE}, LAST_ROUND=11, P6_START=6.
//  Sub-module ascon_round: purely combinational one round (state_t, r -> state_t);
//    instantiated once, or twice in series under ASCON_PERM_UNROLL2_EN.
// TESTING
//  1 reset: assert rst_i mid-RUN -> next cycle in_ready_o=1, out_valid_o=0, state_o=0.
//  2 p12, state_i=0 -> out_valid_o exactly after edge e0+12; state_o == golden Ascon p12(0).
//  3 p6, state_i=Ascon-128 IV||K||N vector -> valid after e0+6; matches golden p6; first
//    round constant 0x96 visible in x2 via internal probe.
//  4 backpressure: out_ready_i=0 for 20 cycles -> out_valid_o and state_o held, in_ready_o=0,
//    in_valid_i pulses ignored; release -> IDLE next edge.
//  5 back-to-back: 100 random states/modes, out_ready_i=1 -> all match model, 14/8-cycle cadence.
//  6 rebuild with ASCON_PERM_UNROLL2_EN -> tests 2-5 pass with latencies 6/3.

Source files
------------

// File: rtl/ascon_perm_core_pkg.sv
// rtl/ascon_perm_core_pkg.sv - Ascon permutation types, constants and helpers
// State word x_i lives at element i of state_t; packed form puts x0 at the top.
package ascon_perm_core_pkg;

   localparam int STATE_W = 320;
   localparam int ROUND_W = 4;

   localparam logic [ROUND_W-1:0] LAST_ROUND = 4'd11;
   localparam logic [ROUND_W-1:0] P6_START   = 4'd6;

   localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
   localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

   typedef logic [63:0] word_t;
   typedef word_t [4:0] state_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   function automatic state_t unpack_state(input logic [STATE_W-1:0] v);
      state_t s;
      for (int i = 0; i < 5; i++) s[i] = v[STATE_W-1-64*i -: 64];
      return s;
   endfunction

   function automatic logic [STATE_W-1:0] pack_state(input state_t s);
      logic [STATE_W-1:0] v;
      for (int i = 0; i < 5; i++) v[STATE_W-1-64*i -: 64] = s[i];
      return v;
   endfunction

   function automatic logic [7:0] round_const(input logic [ROUND_W-1:0] r);
      return {4'hF - r, r};
   endfunction

   function automatic word_t ror64(input word_t v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

endpackage

// File: rtl/ascon_perm_core_if.sv
// rtl/ascon_perm_core_if.sv - state-in / state-out handshake bundle of the permutation core
// master = mode controller side, slave = permutation core side.
interface ascon_perm_core_if;
   import ascon_perm_core_pkg::*;

   logic               in_valid_i;
   logic               in_ready_o;
   logic               p12_i;
   logic [STATE_W-1:0] state_i;
   logic               out_valid_o;
   logic               out_ready_i;
   logic [STATE_W-1:0] state_o;
   logic               busy_o;

   modport master (
      output in_valid_i, p12_i, state_i, out_ready_i,
      input  in_ready_o, out_valid_o, state_o, busy_o
   );

   modport slave (
      input  in_valid_i, p12_i, state_i, out_ready_i,
      output in_ready_o, out_valid_o, state_o, busy_o
   );

endinterface

// File: rtl/ascon_perm_core_round.sv
// rtl/ascon_perm_core_round.sv - one combinational Ascon round (constant, S-box, linear layer)
module ascon_perm_core_round
   import ascon_perm_core_pkg::*;
(
   input  state_t             s_i,
   input  logic [ROUND_W-1:0] round_i,
   output state_t             s_o
);

   logic [7:0] rc_w;
   state_t     x;
   state_t     t;

   assign rc_w = round_const(round_i);

   always_comb begin
      x = s_i;
      x[2][7:0] = x[2][7:0] ^ rc_w;
      // bitsliced 5-bit S-box applied to all 64 columns at once
      x[0] = x[0] ^ x[4];
      x[4] = x[4] ^ x[3];
      x[2] = x[2] ^ x[1];
      for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i+1)%5];
      for (int i = 0; i < 5; i++) x[i] = x[i] ^ t[(i+1)%5];
      x[1] = x[1] ^ x[0];
      x[0] = x[0] ^ x[4];
      x[3] = x[3] ^ x[2];
      x[2] = ~x[2];
      for (int i = 0; i < 5; i++)
         s_o[i] = x[i] ^ ror64(x[i], ROT_A[i]) ^ ror64(x[i], ROT_B[i]);
   end

endmodule

// File: rtl/ascon_perm_core.sv
// rtl/ascon_perm_core.sv - iterative Ascon p12/p6 permutation engine with valid/ready ports
// ASCON_PERM_UNROLL2_EN: two cascaded rounds per cycle instead of one.
module ascon_perm_core
   import ascon_perm_core_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   ascon_perm_core_if.slave   bus
);

   fsm_t               state_q, state_d;
   logic [ROUND_W-1:0] round_q, round_d;
   state_t             st_q, st_d;
   state_t             rnd_out;
   logic               last_w;

`ifdef ASCON_PERM_UNROLL2_EN
   localparam logic [ROUND_W-1:0] STEP = 4'd2;
   state_t rnd_mid;

   ascon_perm_core_round u_round0 (.s_i(st_q),    .round_i(round_q),         .s_o(rnd_mid));
   ascon_perm_core_round u_round1 (.s_i(rnd_mid), .round_i(round_q + 4'd1),  .s_o(rnd_out));

   // both start indices are even, so the final pair always begins at 10
   assign last_w = (round_q == LAST_ROUND - 4'd1);
`else
   localparam logic [ROUND_W-1:0] STEP = 4'd1;

   ascon_perm_core_round u_round0 (.s_i(st_q), .round_i(round_q), .s_o(rnd_out));

   assign last_w = (round_q == LAST_ROUND);
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         round_q <= '0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         st_q    <= st_d;
      end
   end

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      st_d    = st_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid_i) begin
               state_d = RUN;
               st_d    = unpack_state(bus.state_i);
               round_d = bus.p12_i ? '0 : P6_START;
            end
         end
         RUN: begin
            st_d = rnd_out;
            if (last_w) state_d = DONE;
            else        round_d = round_q + STEP;
         end
         DONE: begin
            if (bus.out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready_o  = (state_q == IDLE);
   assign bus.out_valid_o = (state_q == DONE);
   assign bus.busy_o      = (state_q == RUN) || (state_q == DONE);
   assign bus.state_o     = pack_state(st_q);

endmodule

// File: tb/tb_ascon_perm_core.sv
// tb/tb_ascon_perm_core.sv - self-checking bench for ascon_perm_core (either build)
module tb_ascon_perm_core;

`ifdef ASCON_PERM_UNROLL2_EN
   localparam int LAT12 = 6;
   localparam int LAT6  = 3;
`else
   localparam int LAT12 = 12;
   localparam int LAT6  = 6;
`endif

   // Ascon 5-bit S-box lookup table, input/output bit 4 = x0
   localparam logic [4:0] SBOX [0:31] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   localparam int RA [5] = '{19, 61, 1, 10, 7};
   localparam int RB [5] = '{28, 39, 6, 17, 41};

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   ascon_perm_core_if bus();

   ascon_perm_core dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   function automatic logic [319:0] model_perm(input logic [319:0] s, input bit p12);
      logic [63:0]  w [5];
      logic [4:0]   idx, o;
      logic [127:0] dd;
      logic [63:0]  ta, tb;
      logic [3:0]   r;
      for (int i = 0; i < 5; i++) w[i] = s[319-64*i -: 64];
      for (int rr = (p12 ? 0 : 6); rr < 12; rr++) begin
         r = rr[3:0];
         w[2][7:0] = w[2][7:0] ^ {4'hF - r, r};
         for (int b = 0; b < 64; b++) begin
            idx = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
            o = SBOX[idx];
            w[0][b] = o[4]; w[1][b] = o[3]; w[2][b] = o[2]; w[3][b] = o[1]; w[4][b] = o[0];
         end
         for (int i = 0; i < 5; i++) begin
            dd = {w[i], w[i]} >> RA[i];
            ta = dd[63:0];
            dd = {w[i], w[i]} >> RB[i];
            tb = dd[63:0];
            w[i] = w[i] ^ ta ^ tb;
         end
      end
      return {w[0], w[1], w[2], w[3], w[4]};
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] v = '0;
      for (int i = 0; i < 10; i++) v = {v[287:0], $urandom()};
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [319:0] s, input bit p12, output logic [7:0] rc0);
      bus.in_valid_i = 1'b1;
      bus.state_i    = s;
      bus.p12_i      = p12;
      tick();
      bus.in_valid_i = 1'b0;
      bus.state_i    = rand320();
      rc0 = dut.u_round0.rc_w;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.out_valid_o && lat < 40);
   endtask

   task automatic test_reset();
      logic [7:0] rc;
      int seen;
      rst = 1'b1;
      bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0; bus.p12_i = 1'b0; bus.state_i = '0;
      tick(); tick();
      rst = 1'b0;
      n_tests++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready_o); end
      n_tests++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid_o); end
      n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy_o); end
      n_tests++; if (bus.state_o !== '0) begin n_fail++; $display("FAIL rst_state: got %h expected 0", bus.state_o); end
      start(rand320(), 1'b1, rc);
      tick(); tick();
      n_tests++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL run_busy: got %b expected 1", bus.busy_o); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b expected 1", bus.in_ready_o); end
      n_tests++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %b expected 0", bus.out_valid_o); end
      n_tests++; if (bus.state_o !== '0) begin n_fail++; $display("FAIL abort_state: got %h expected 0", bus.state_o); end
      n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy_o); end
      seen = 0;
      repeat (15) begin tick(); if (bus.out_valid_o !== 1'b0) seen++; end
      n_tests++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_result: got %0d valid cycles expected 0", seen); end
   endtask

   task automatic test_p12_zero();
      logic [7:0] rc;
      logic [319:0] exp_s;
      int lat;
      exp_s = model_perm('0, 1'b1);
      bus.out_ready_i = 1'b0;
      start('0, 1'b1, rc);
      n_tests++; if (rc !== 8'hF0) begin n_fail++; $display("FAIL p12_rc0: got %h expected f0", rc); end
      wait_valid(lat);
      n_tests++; if (lat != LAT12) begin n_fail++; $display("FAIL p12_latency: got %0d expected %0d", lat, LAT12); end
      n_tests++; if (bus.state_o !== exp_s) begin n_fail++; $display("FAIL p12_zero_state: got %h expected %h", bus.state_o, exp_s); end
      bus.out_ready_i = 1'b1;
      tick();
      n_tests++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL p12_release_ready: got %b expected 1", bus.in_ready_o); end
      n_tests++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL p12_release_valid: got %b expected 0", bus.out_valid_o); end
      bus.out_ready_i = 1'b0;
   endtask

   task automatic test_p6_iv();
      logic [7:0] rc;
      logic [319:0] s, exp_s;
      int lat;
      s = {64'h80400c0600000000, 128'h000102030405060708090a0b0c0d0e0f,
           128'h101112131415161718191a1b1c1d1e1f};
      exp_s = model_perm(s, 1'b0);
      start(s, 1'b0, rc);
      n_tests++; if (rc !== 8'h96) begin n_fail++; $display("FAIL p6_rc0: got %h expected 96", rc); end
      wait_valid(lat);
      n_tests++; if (lat != LAT6) begin n_fail++; $display("FAIL p6_latency: got %0d expected %0d", lat, LAT6); end
      n_tests++; if (bus.state_o !== exp_s) begin n_fail++; $display("FAIL p6_iv_state: got %h expected %h", bus.state_o, exp_s); end
      bus.out_ready_i = 1'b1;
      tick();
      bus.out_ready_i = 1'b0;
      n_tests++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL p6_release_ready: got %b expected 1", bus.in_ready_o); end
   endtask

   task automatic test_backpressure();
      logic [7:0] rc;
      logic [319:0] s, exp_s;
      int lat;
      s = rand320();
      exp_s = model_perm(s, 1'b1);
      bus.out_ready_i = 1'b0;
      start(s, 1'b1, rc);
      wait_valid(lat);
      n_tests++; if (lat != LAT12) begin n_fail++; $display("FAIL bp_latency: got %0d expected %0d", lat, LAT12); end
      for (int i = 0; i < 20; i++) begin
         bus.in_valid_i = i[0];
         bus.p12_i      = ~i[1];
         bus.state_i    = rand320();
         tick();
         n_tests++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold[%0d]: got %b expected 1", i, bus.out_valid_o); end
         n_tests++; if (bus.state_o !== exp_s) begin n_fail++; $display("FAIL bp_state_hold[%0d]: got %h expected %h", i, bus.state_o, exp_s); end
         n_tests++; if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready_o); end
      end
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      tick();
      n_tests++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready_o); end
      n_tests++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", bus.out_valid_o); end
      tick();
      n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_pulses_ignored: busy got %b expected 0", bus.busy_o); end
      bus.out_ready_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [319:0] vin [100];
      logic [319:0] vexp [100];
      bit           vp [100];
      int           acc_t [100];
      int           out_t [100];
      int           cyc, k_in, k_out, lat;
      bit           acc;
      for (int k = 0; k < 100; k++) begin
         vin[k]  = rand320();
         vp[k]   = 1'($urandom_range(0, 1));
         vexp[k] = model_perm(vin[k], vp[k]);
         acc_t[k] = 0;
         out_t[k] = 0;
      end
      cyc = 0; k_in = 0; k_out = 0;
      bus.out_ready_i = 1'b1;
      bus.in_valid_i  = 1'b1;
      bus.state_i     = vin[0];
      bus.p12_i       = vp[0];
      while (k_out < 100 && cyc < 4000) begin
         acc = bus.in_valid_i && bus.in_ready_o;
         tick();
         cyc++;
         if (acc && k_in < 100) begin
            acc_t[k_in] = cyc;
            k_in++;
            if (k_in < 100) begin
               bus.state_i = vin[k_in];
               bus.p12_i   = vp[k_in];
            end else begin
               bus.in_valid_i = 1'b0;
            end
         end
         if (bus.out_valid_o) begin
            lat = vp[k_out] ? LAT12 : LAT6;
            n_tests++; if (bus.state_o !== vexp[k_out]) begin n_fail++; $display("FAIL b2b_state[%0d]: got %h expected %h", k_out, bus.state_o, vexp[k_out]); end
            n_tests++; if (cyc - acc_t[k_out] != lat) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", k_out, cyc - acc_t[k_out], lat); end
            out_t[k_out] = cyc;
            if (k_out > 0) begin
               n_tests++; if (cyc - out_t[k_out-1] != lat + 2) begin n_fail++; $display("FAIL b2b_cadence[%0d]: got %0d expected %0d", k_out, cyc - out_t[k_out-1], lat + 2); end
            end
            k_out++;
         end
      end
      n_tests++; if (k_out != 100) begin n_fail++; $display("FAIL b2b_count: got %0d expected 100", k_out); end
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_p12_zero();
      test_p6_iv();
      test_backpressure();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
